// File: rtl/perf_pkg.sv
// -----------------------------------------------------------------------------
// perf_pkg
// Shared constants for the performance-counter bank of the single-cycle MIPS
// core: the counter index map, the number of counters and the opcode of the
// perf (read counter) instruction that the decoder matches against.
// -----------------------------------------------------------------------------
package perf_pkg;

    localparam int PERF_NUM_CNT = 8;

    // Counter index map; also the value of perf_sel / imm[2:0]
    localparam logic [2:0] PERF_CYCLES  = 3'd0;
    localparam logic [2:0] PERF_INSTR   = 3'd1;
    localparam logic [2:0] PERF_LOADS   = 3'd2;
    localparam logic [2:0] PERF_STORES  = 3'd3;
    localparam logic [2:0] PERF_JUMPS   = 3'd4;
    localparam logic [2:0] PERF_BRANCH  = 3'd5;
    localparam logic [2:0] PERF_TAKEN   = 3'd6;
    localparam logic [2:0] PERF_REGWR   = 3'd7;

    // Opcode of the perf instruction (write-back selects perf_data via
    // mem_to_reg = 2'b11)
    localparam logic [5:0] PERF_OPCODE  = 6'b110011;

endpackage

// File: rtl/perf_counter.sv
// -----------------------------------------------------------------------------
// perf_counter
// One CNT_W-bit event counter with a sticky overflow flag.
//
// Ports:
//   clk     in   core clock, rising edge
//   reset   in   asynchronous active-high reset, clears count and ovf
//   inc     in   count one event this cycle
//   clr     in   clear count and ovf; wins over inc and ignores freeze
//   freeze  in   hold the count (clears still apply)
//   count   out  current counter value
//   ovf     out  sticky overflow flag
//
// Build option: PERF_SATURATE_EN defined -> a counter at its maximum stays
// there on increment; otherwise it wraps to zero. Both set ovf.
// -----------------------------------------------------------------------------
module perf_counter
    import perf_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic             freeze,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic at_max;

    assign at_max = &count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            // Clear drops any event arriving in the same cycle
            count <= '0;
            ovf   <= 1'b0;
        end else if (inc && !freeze) begin
            if (at_max) begin
                ovf <= 1'b1;
`ifdef PERF_SATURATE_EN
                count <= count;
`else
                count <= '0;
`endif
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/perf_counter_unit.sv
// -----------------------------------------------------------------------------
// perf_counter_unit
// Performance-counter bank fed by the main controller strobes. Eight counters
// (see perf_pkg for the index map); the selected counter is read back
// combinationally through perf_data for the perf instruction's write-back.
//
// Ports:
//   clk, reset          core clock, asynchronous active-high reset
//   instr_valid         an instruction retires this cycle (gates counters 1..7)
//   jump, branch, branch_taken, mem_read, mem_write, reg_write
//                       controller strobes
//   perf_sel            counter index for read and single clear
//   perf_clr            clear counter perf_sel
//   perf_clr_all        clear every counter and ovf flag (overrides perf_clr)
//   perf_freeze         hold all counters including cycles
//   perf_data           selected counter, zero-extended to 32 bits
//   perf_ovf            sticky overflow flag per counter
//
// Build option: PERF_SATURATE_EN selects saturating instead of wrapping
// counters (implemented inside perf_counter).
// -----------------------------------------------------------------------------
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic        jump,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic [2:0]  perf_sel,
    input  logic        perf_clr,
    input  logic        perf_clr_all,
    input  logic        perf_freeze,
    output logic [31:0] perf_data,
    output logic [7:0]  perf_ovf
);

    logic [PERF_NUM_CNT-1:0] inc;
    logic [PERF_NUM_CNT-1:0] clr;
    logic [PERF_NUM_CNT-1:0] ovf;
    logic [CNT_W-1:0]        count [PERF_NUM_CNT];

    // Event gating: cycles always counts, the rest need a retiring instruction.
    // branch_taken is only meaningful together with branch.
    always_comb begin
        inc              = '0;
        inc[PERF_CYCLES] = 1'b1;
        inc[PERF_INSTR]  = instr_valid;
        inc[PERF_LOADS]  = instr_valid & mem_read;
        inc[PERF_STORES] = instr_valid & mem_write;
        inc[PERF_JUMPS]  = instr_valid & jump;
        inc[PERF_BRANCH] = instr_valid & branch;
        inc[PERF_TAKEN]  = instr_valid & branch & branch_taken;
        inc[PERF_REGWR]  = instr_valid & reg_write;
    end

    always_comb begin
        clr = '0;
        if (perf_clr_all) begin
            clr = '1;
        end else if (perf_clr) begin
            clr[perf_sel] = 1'b1;
        end
    end

    for (genvar i = 0; i < PERF_NUM_CNT; i++) begin : g_cnt
        perf_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .inc    (inc[i]),
            .clr    (clr[i]),
            .freeze (perf_freeze),
            .count  (count[i]),
            .ovf    (ovf[i])
        );
    end

    // Zero-latency read: returns the registered (pre-update) value
    always_comb begin
        perf_data              = '0;
        perf_data[CNT_W-1:0]   = count[perf_sel];
    end

    assign perf_ovf = ovf;

endmodule
